// File: rtl/gen_obstaculos.sv
// gen_obstaculos: picks pseudo-random obstacle types for the pattern ROM and
// scrolls the returned rows down a FILAS-row field toward the hero row.
module gen_obstaculos #(
  parameter int         FILAS   = 8,
  parameter int         ESPACIO = 2,
  parameter logic [7:0] SEMILLA = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               reinicio,
  input  logic               tick,
  input  logic [2:0]         pos_heroe,
  input  logic [6:0]         obstaculo,
  output logic [3:0]         tipo_obs,
  output logic [7*FILAS-1:0] campo,
  output logic               colision,
  output logic [7:0]         puntos,
  output logic               jugando
);

  localparam int GW = (ESPACIO > 0) ? $clog2(ESPACIO + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    JUGANDO,
    CHOQUE
  } estado_t;

  estado_t       estado;
  estado_t       estado_sig;
  logic [7:0]    lfsr;
  logic [7:0]    lfsr_sig;
  logic [GW-1:0] gap;
  logic [6:0]    fila_heroe;
  logic [7:0]    fila_ext;
  logic [6:0]    fila_nueva;
  logic          choque;
  logic          avanza;
  logic          inserta;

  // Column 7 maps onto the padding bit, so "no column" can never collide.
  assign fila_heroe = campo[7*(FILAS-1) +: 7];
  assign fila_ext   = {1'b0, fila_heroe};
  assign choque     = (pos_heroe != 3'd7) && fila_ext[pos_heroe];

  assign avanza     = (estado == JUGANDO) && tick && !reinicio;
  assign inserta    = (gap == '0);
  assign fila_nueva = inserta ? obstaculo : 7'd0;
  assign lfsr_sig   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  assign tipo_obs = lfsr[3:0];
  assign colision = (estado == CHOQUE);
  assign jugando  = (estado == JUGANDO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado <= IDLE;
    end else begin
      estado <= estado_sig;
    end
  end

  always_comb begin
    estado_sig = estado;
    if (reinicio) begin
      estado_sig = IDLE;
    end else begin
      case (estado)
        IDLE:    if (en) estado_sig = JUGANDO;
        JUGANDO: if (choque) estado_sig = CHOQUE;
        CHOQUE:  estado_sig = CHOQUE;
        default: estado_sig = IDLE;
      endcase
    end
  end

  // The field only moves on a tick while playing; in CHOQUE it stays frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr   <= SEMILLA;
      campo  <= '0;
      puntos <= '0;
      gap    <= '0;
    end else if (reinicio) begin
      lfsr   <= SEMILLA;
      campo  <= '0;
      puntos <= '0;
      gap    <= '0;
    end else if (avanza) begin
      campo <= {campo[7*(FILAS-1)-1:0], fila_nueva};
      if (inserta) begin
        lfsr <= lfsr_sig;
        gap  <= GW'(ESPACIO);
      end else begin
        gap <= gap - GW'(1);
      end
      if ((fila_heroe != 7'd0) && (puntos != 8'hFF)) begin
        puntos <= puntos + 8'd1;
      end
    end
  end

endmodule
